// File: rtl/alu_mdu_if.sv
// Handshake bundle between the execute stage and the ALU/MDU.
// master drives requests and consumes results; slave is the ALU/MDU.
interface alu_mdu_if #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_NUM     = 19
);
    logic                  in_valid;
    logic                  in_ready;
    logic [OP_NUM-1:0]     alu_op;
    logic [DATA_WIDTH-1:0] alu_src1;
    logic [DATA_WIDTH-1:0] alu_src2;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  out_err;

    modport master (
        output in_valid, alu_op, alu_src1, alu_src2, out_ready,
        input  in_ready, out_valid, alu_result, out_err
    );

    modport slave (
        input  in_valid, alu_op, alu_src1, alu_src2, out_ready,
        output in_ready, out_valid, alu_result, out_err
    );
endinterface

// File: rtl/alu_mdu.sv
// Integer ALU with single-cycle multiply and iterative restoring divide/modulo.
// state | meaning: IDLE no result held | BUSY dividing | OUT result held until drained
module alu_mdu #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_NUM     = 19,
    parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
    input logic      clk,
    input logic      resetn,
    alu_mdu_if.slave bus
);
    localparam int W = DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, BUSY, OUT} state_t;

    state_t             state_q;
    logic [W-1:0]       result_q;
    logic               err_q;
    logic               valid_q;
    logic [W-1:0]       rem_q;
    logic [W-1:0]       quot_q;
    logic [W-1:0]       dvsr_q;
    logic [SHAMT_W-1:0] cnt_q;
    logic               neg_quot_q;
    logic               neg_rem_q;
    logic               is_mod_q;

    logic [W-1:0]       a, b;
    logic [SHAMT_W-1:0] shamt;
    logic               accept, op_onehot, div_start;
    logic               signed_div, a_neg, b_neg;
    logic [W-1:0]       a_mag, b_mag;
    logic [2*W-1:0]     prod_u;
    logic [W-1:0]       mulh;
    logic [W-1:0]       alu_res;

    assign a     = bus.alu_src1;
    assign b     = bus.alu_src2;
    assign shamt = a[SHAMT_W-1:0];

    assign bus.in_ready   = (state_q == IDLE) || (state_q == OUT && bus.out_ready);
    assign bus.out_valid  = valid_q;
    assign bus.alu_result = result_q;
    assign bus.out_err    = err_q;

    assign accept     = bus.in_valid && bus.in_ready;
    assign op_onehot  = $onehot(bus.alu_op);
    assign div_start  = op_onehot && (|bus.alu_op[18:15]) && (b != '0);
    assign signed_div = bus.alu_op[15] | bus.alu_op[17];
    assign a_neg      = signed_div & a[W-1];
    assign b_neg      = signed_div & b[W-1];
    assign a_mag      = a_neg ? -a : a;
    assign b_mag      = b_neg ? -b : b;

    // Signed high half recovered from the unsigned product by subtracting
    // the cross terms of negative operands, so one multiplier serves all three.
    assign prod_u = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    assign mulh   = prod_u[2*W-1:W] - (a[W-1] ? b : '0) - (b[W-1] ? a : '0);

    always_comb begin
        alu_res = '0;
        if (op_onehot) begin
            case (1'b1)
                bus.alu_op[0]:  alu_res = a + b;
                bus.alu_op[1]:  alu_res = a - b;
                bus.alu_op[2]:  alu_res = {{(W-1){1'b0}}, $signed(a) < $signed(b)};
                bus.alu_op[3]:  alu_res = {{(W-1){1'b0}}, a < b};
                bus.alu_op[4]:  alu_res = a & b;
                bus.alu_op[5]:  alu_res = ~(a | b);
                bus.alu_op[6]:  alu_res = a | b;
                bus.alu_op[7]:  alu_res = a ^ b;
                bus.alu_op[8]:  alu_res = b << shamt;
                bus.alu_op[9]:  alu_res = b >> shamt;
                bus.alu_op[10]: alu_res = $signed(b) >>> shamt;
                bus.alu_op[11]: alu_res = {b[W/2-1:0], {(W/2){1'b0}}};
                bus.alu_op[12]: alu_res = prod_u[W-1:0];
                bus.alu_op[13]: alu_res = mulh;
                bus.alu_op[14]: alu_res = prod_u[2*W-1:W];
                // Div-class reaches here only with a zero divisor.
                bus.alu_op[15], bus.alu_op[16]: alu_res = '1;
                bus.alu_op[17], bus.alu_op[18]: alu_res = a;
                default:        alu_res = '0;
            endcase
        end
    end

    logic [W:0]   trial, diff;
    logic         step_ge;
    logic [W-1:0] rem_nx, quot_nx, quot_fin, rem_fin;

    assign trial    = {rem_q, quot_q[W-1]};
    assign diff     = trial - {1'b0, dvsr_q};
    assign step_ge  = !diff[W];
    assign rem_nx   = step_ge ? diff[W-1:0] : trial[W-1:0];
    assign quot_nx  = {quot_q[W-2:0], step_ge};
    assign quot_fin = neg_quot_q ? -quot_nx : quot_nx;
    assign rem_fin  = neg_rem_q ? -rem_nx : rem_nx;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= IDLE;
            valid_q    <= 1'b0;
            result_q   <= '0;
            err_q      <= 1'b0;
            rem_q      <= '0;
            quot_q     <= '0;
            dvsr_q     <= '0;
            cnt_q      <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            is_mod_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, OUT: begin
                    if (accept) begin
                        if (div_start) begin
                            state_q    <= BUSY;
                            valid_q    <= 1'b0;
                            rem_q      <= '0;
                            quot_q     <= a_mag;
                            dvsr_q     <= b_mag;
                            cnt_q      <= '0;
                            neg_quot_q <= a_neg ^ b_neg;
                            neg_rem_q  <= a_neg;
                            is_mod_q   <= bus.alu_op[17] | bus.alu_op[18];
                        end else begin
                            state_q  <= OUT;
                            valid_q  <= 1'b1;
                            result_q <= alu_res;
                            err_q    <= !op_onehot;
                        end
                    end else if (state_q == OUT && bus.out_ready) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                    end
                end
                BUSY: begin
                    rem_q  <= rem_nx;
                    quot_q <= quot_nx;
                    cnt_q  <= cnt_q + SHAMT_W'(1);
                    if (cnt_q == SHAMT_W'(W-1)) begin
                        state_q  <= OUT;
                        valid_q  <= 1'b1;
                        result_q <= is_mod_q ? rem_fin : quot_fin;
                        err_q    <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
